// File: rtl/alu_pkg.sv
// Shared ALU definitions: sequencer state encodings and width helpers
// used by the multi-cycle arithmetic blocks.
package alu_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Width of an iteration counter that must reach n-1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ADD.sv
// Ripple-carry adder built from explicit full-adder gates.
// The carry out of the top bit is discarded; callers widen the operands when they need it.
module ADD #(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] s
);

  logic [W-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign s[i] = a[i] ^ b[i] ^ c[i];
    if (i < W - 1) begin : g_carry
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
  end

endmodule

// File: rtl/shift_add_mul.sv
// Unsigned N x N multiplier, one add-and-shift step per clock.
//   state | meaning
//   IDLE  | waiting for start, P holds the last product
//   RUN   | N add/shift iterations, busy=1
//   DONE  | one-cycle done pulse, then back to IDLE
module shift_add_mul
  import alu_pkg::*;
#(
  parameter int N = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] P
);

  localparam int CW = cnt_width(N);

  logic [1:0]     state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   mcand;
  logic [2*N-1:0] prod;
  logic [N:0]     addend;
  logic [N:0]     sum;

  assign addend = prod[0] ? {1'b0, mcand} : '0;

  // N+1 bit add keeps the carry so the shift never loses the top bit.
  ADD #(.W(N + 1)) u_add (
    .a ({1'b0, prod[2*N-1:N]}),
    .b (addend),
    .s (sum)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      mcand <= '0;
      prod  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            mcand <= A;
            prod  <= {{N{1'b0}}, B};
            cnt   <= '0;
            state <= ST_RUN;
          end
        end
        ST_RUN: begin
          prod <= {sum, prod[N-1:1]};
          cnt  <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);
  assign P    = prod;

endmodule

// File: tb/tb_shift_add_mul.sv
// Scoreboarded bench for shift_add_mul: N=8 instance for the main cases,
// N=32 instance for back-to-back operation with start held high.
module tb_shift_add_mul;

  logic        clk = 1'b0;
  logic        rst;
  logic        start8, start32;
  logic [7:0]  a8, b8;
  logic [31:0] a32, b32;
  logic        busy8, done8, busy32, done32;
  logic [15:0] p8;
  logic [63:0] p32;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] q8[$];
  logic [63:0] q32[$];

  always #5 clk = ~clk;

  shift_add_mul #(.N(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8),
    .busy(busy8), .done(done8), .P(p8)
  );

  shift_add_mul #(.N(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .A(a32), .B(b32),
    .busy(busy32), .done(done32), .P(p32)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every done pulse consumes one expected product.
  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      if (q8.size() == 0) check("done8_unexpected", {63'b0, done8}, 64'd0);
      else                check("p8_result", 64'(p8), q8.pop_front());
    end
    if (done32 === 1'b1) begin
      if (q32.size() == 0) check("done32_unexpected", {63'b0, done32}, 64'd0);
      else                 check("p32_result", p32, q32.pop_front());
    end
  end

  // Called at a falling edge; start is seen by the next rising edge.
  task automatic op8(input logic [7:0] a, input logic [7:0] b);
    int k;
    int nb;
    logic [63:0] prod;
    k = 0;
    nb = 0;
    prod = 64'(a) * 64'(b);
    a8 = a;
    b8 = b;
    start8 = 1'b1;
    q8.push_back(prod);
    @(posedge clk);
    #1 start8 = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (done8) begin
        k = i;
        break;
      end
      if (busy8) nb++;
    end
    check("latency8", 64'(k), 64'd9);
    check("busy_cycles8", 64'(nb), 64'd8);
    @(negedge clk);
    check("p8_hold", 64'(p8), prod);
    check("done8_single", {63'b0, done8}, 64'd0);
  endtask

  initial begin
    int nb;
    int nd;
    int seen;
    int t[3];

    rst = 1'b1;
    start8 = 1'b0;  start32 = 1'b0;
    a8 = '0;  b8 = '0;  a32 = '0;  b32 = '0;
    repeat (2) @(negedge clk);
    check("rst_p8", 64'(p8), 64'd0);
    check("rst_busy8", {63'b0, busy8}, 64'd0);
    check("rst_done8", {63'b0, done8}, 64'd0);
    check("rst_p32", p32, 64'd0);

    // Start on the first edge after reset release.
    rst = 1'b0;
    op8(8'd13, 8'd11);
    op8(8'd255, 8'd255);
    op8(8'd0, 8'd200);
    op8(8'd200, 8'd0);
    for (int r = 0; r < 3; r++) op8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));

    // Second start during RUN must be ignored.
    a8 = 8'd7;  b8 = 8'd9;  start8 = 1'b1;
    q8.push_back(64'd63);
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (3) @(negedge clk);
    a8 = 8'd3;  b8 = 8'd3;  start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done8) begin
        seen = 1;
        break;
      end
    end
    check("ignored_start_done_seen", 64'(seen), 64'd1);
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8 || done8) nb++;
    end
    check("ignored_start_no_rerun", 64'(nb), 64'd0);
    check("ignored_start_p8", 64'(p8), 64'd63);

    // Asynchronous reset in the middle of RUN.
    a8 = 8'd100;  b8 = 8'd100;  start8 = 1'b1;
    @(posedge clk);
    #1 start8 = 1'b0;
    repeat (4) @(negedge clk);
    check("midrun_busy_before_rst", {63'b0, busy8}, 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_p8", 64'(p8), 64'd0);
    check("async_rst_busy8", {63'b0, busy8}, 64'd0);
    check("async_rst_done8", {63'b0, done8}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy8 || done8) nb++;
    end
    check("no_resume_after_rst", 64'(nb), 64'd0);
    op8(8'd5, 8'd6);

    // N=32, start held high across three operations.
    a32 = 32'hFFFF_FFFF;  b32 = 32'd2;  start32 = 1'b1;
    for (int j = 0; j < 3; j++) q32.push_back(64'h1_FFFF_FFFE);
    nd = 0;
    t[0] = 0;  t[1] = 0;  t[2] = 0;
    for (int i = 1; i <= 150; i++) begin
      @(negedge clk);
      if (done32) begin
        t[nd] = i;
        nd++;
        if (nd == 3) begin
          start32 = 1'b0;
          break;
        end
      end
    end
    check("n32_done_count", 64'(nd), 64'd3);
    check("n32_first_latency", 64'(t[0]), 64'd33);
    check("n32_period_1", 64'(t[1] - t[0]), 64'd34);
    check("n32_period_2", 64'(t[2] - t[1]), 64'd34);
    repeat (4) @(negedge clk);
    check("n32_idle_after", {63'b0, busy32}, 64'd0);
    check("n32_p_hold", p32, 64'h1_FFFF_FFFE);
    check("q8_drained", 64'(q8.size()), 64'd0);
    check("q32_drained", 64'(q32.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/shift_add_mul.md
SHIFT_ADD_MUL -- requirements
Module: shift_add_mul

Interface
REQ-001 Parameter N SHALL have default 32 and set the operand width in bits; legal range 2..32.
REQ-002 Port clk SHALL be an input, 1 bit wide, and is the single clock; all state updates occur on its rising edge.
REQ-003 Port rst SHALL be an input, 1 bit wide, and is the asynchronous, active-high reset.
REQ-004 Port start SHALL be an input, 1 bit wide, and requests a new multiply when high in IDLE.
REQ-005 Port A SHALL be an input, N bits wide, and is the unsigned multiplicand, sampled at accepted start.
REQ-006 Port B SHALL be an input, N bits wide, and is the unsigned multiplier, sampled at accepted start.
REQ-007 Port busy SHALL be an output, 1 bit wide, and is high while in RUN.
REQ-008 Port done SHALL be an output, 1 bit wide, and is a single-cycle pulse marking that P is valid.
REQ-009 Port P SHALL be an output, 2N bits wide, and is the unsigned product A*B.

Function
REQ-010 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-011 In IDLE, a clock edge with start=1 SHALL capture A into the multiplicand register, load {N'b0, B} into the product register, clear the cycle counter to 0, and enter RUN.
REQ-012 In RUN, each cycle SHALL compute sum = product[2N-1:N] + (product[0] ? multiplicand : 0) at N+1 bits, then load product <= {sum, product[N-1:1]}; this is an add followed by a right shift.
REQ-013 RUN SHALL last exactly N cycles, with the counter incrementing each cycle; when the counter equals N-1, the next state SHALL be DONE.
REQ-014 DONE SHALL last one cycle with done=1, then return to IDLE unconditionally.
REQ-015 Latency SHALL be N+1 edges from the accepted start to the done pulse, i.e. 33 for N=32.
REQ-016 P SHALL be driven from the product register, and SHALL hold the last result in IDLE until the next accepted start.
REQ-017 start SHALL be ignored in RUN and DONE, with no queuing; start held high continuously SHALL be accepted again on the first IDLE cycle after DONE.
REQ-018 The adder carry-out at bit N SHALL be retained through the shift; no overflow is possible, and (2^N-1)^2 SHALL be represented exactly.
REQ-019 A=0 or B=0 SHALL still take the full N cycles and produce P=0.
REQ-020 busy SHALL equal (state==RUN), and done SHALL equal (state==DONE); both outputs are registered-state decodes with no combinational path from start.

Reset
REQ-021 Asserting rst at any time, including mid-RUN, SHALL force IDLE, counter=0, product=0, multiplicand=0, busy=0, done=0 and P=0 immediately, without waiting for clk.
REQ-022 A start that is high on the first edge after rst deasserts SHALL be accepted normally.
REQ-023 A multiply interrupted by reset SHALL NOT resume and SHALL NOT assert done.

Structure
REQ-024 State encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) SHALL be defined as constants in the shared ALU package, alu_pkg.
REQ-025 The counter width SHALL be computed as $clog2(N) from the same package and SHALL NOT be hard-coded.
REQ-026 The addition SHALL be performed by one instance of the existing ripple-carry adder module ADD, parameterised to N+1 bits with zero-extended operands.
REQ-027 No other arithmetic operators SHALL be used on the datapath; the counter increment is exempt.
REQ-028 The FSM, counter and datapath registers SHALL reside in shift_add_mul; no further sub-modules SHALL be created.

Verification (N=8 unless stated)
REQ-029 start with A=13, B=11 -> busy high for 8 cycles, done pulses on the 9th edge, P=143, and P holds 143 afterwards.
REQ-030 start with A=255, B=255 -> P=65025 (0xFE01), exercising the carry-out at bit N.
REQ-031 start with A=0, B=200 -> exactly 8 busy cycles, then P=0 with done pulsing once.
REQ-032 start with A=7, B=9; pulse start again with A=3, B=3 during RUN -> P=63; the second request is ignored and no extra done occurs.
REQ-033 start with A=100, B=100; assert rst asynchronously at RUN cycle 4 -> outputs become 0 before the next edge; after release, start with A=5, B=6 -> P=30 with no stale done.
REQ-034 With N=32 and start held high across 3 operations using A=0xFFFFFFFF, B=2 -> P=0x1FFFFFFFE each time, with done every 34 cycles.
